// File: rtl/tea_encryptor_pkg.sv
// Shared constants, FSM encoding and the TEA mixing helper for the encryptor.
package tea_encryptor_pkg;

  localparam logic [31:0] TEA_DELTA     = 32'h9E3779B9;
  localparam int          TEA_ROUNDS    = 32;
  // Sum after all rounds; the decryptor starts from this value.
  localparam logic [31:0] TEA_FINAL_SUM = 32'hC6EF3720;

  // FSM encoding kept as plain constants so older blocks can share it.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [31:0] v0;
    logic [31:0] v1;
  } teaBlock_t;

  // One half-round mixing term: ((v<<4)+ka) ^ (v+s) ^ ((v>>5)+kb), mod 2^32.
  function automatic logic [31:0] teaMix(
    input logic [31:0] v,
    input logic [31:0] ka,
    input logic [31:0] kb,
    input logic [31:0] s
  );
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction

endpackage

// File: rtl/tea_encryptor_round.sv
// Combinational single TEA encryption round (v1 update uses the new v0).
module teaEncRound
  import tea_encryptor_pkg::*;
(
  input  logic [31:0]  v0,
  input  logic [31:0]  v1,
  input  logic [31:0]  sumNext,
  input  logic [127:0] key,
  output logic [31:0]  v0New,
  output logic [31:0]  v1New
);

  logic [31:0] k0, k1, k2, k3;

  assign {k0, k1, k2, k3} = key;
  assign v0New = v0 + teaMix(v1, k0, k1, sumNext);
  assign v1New = v1 + teaMix(v0New, k2, k3, sumNext);

endmodule

// File: rtl/tea_encryptor.sv
// Iterative TEA encryptor: one round per enabled clock, 32 rounds per block.
module tea_encryptor
  import tea_encryptor_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         start,
  input  logic [31:0]  dataA,
  input  logic [31:0]  dataB,
  input  logic [127:0] key,
  output logic [31:0]  resultA,
  output logic [31:0]  resultB,
  output logic         busy,
  output logic         rdy
);

  logic [1:0]   state;
  logic [4:0]   roundCnt;
  logic [31:0]  sum;
  logic [31:0]  sumNext;
  teaBlock_t    blk;
  logic [127:0] keyReg;
  logic [31:0]  v0New;
  logic [31:0]  v1New;
  logic         lastRound;

  assign sumNext   = sum + TEA_DELTA;
  assign lastRound = (roundCnt == 5'(TEA_ROUNDS - 1));
  assign busy      = (state == ST_RUN);
  assign rdy       = (state == ST_DONE);

  teaEncRound uRound (
    .v0      (blk.v0),
    .v1      (blk.v1),
    .sumNext (sumNext),
    .key     (keyReg),
    .v0New   (v0New),
    .v1New   (v1New)
  );

  // FSM, round state and result registers; everything holds while ena is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      roundCnt <= '0;
      sum      <= '0;
      blk      <= '0;
      keyReg   <= '0;
      resultA  <= '0;
      resultB  <= '0;
    end else if (ena) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            blk      <= '{v0: dataA, v1: dataB};
            keyReg   <= key;
            sum      <= '0;
            roundCnt <= '0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          // start is deliberately ignored here; the block in flight owns the datapath.
          blk      <= '{v0: v0New, v1: v1New};
          sum      <= sumNext;
          roundCnt <= roundCnt + 5'd1;
          if (lastRound) begin
            resultA <= v0New;
            resultB <= v1New;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          // A start here chains straight into the next block without an IDLE gap.
          if (start) begin
            blk      <= '{v0: dataA, v1: dataB};
            keyReg   <= key;
            sum      <= '0;
            roundCnt <= '0;
            state    <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The round counter and the running sum must agree on the final round.
  finalSumOk: assert property (@(posedge clk) disable iff (rst)
    (ena && state == ST_RUN && lastRound) |-> (sumNext == TEA_FINAL_SUM));

endmodule

// File: tb/tb_tea_encryptor.sv
// Randomized self-checking bench for tea_encryptor against a loop-level TEA model.
module tb_tea_encryptor;

  logic         clk = 1'b0;
  logic         rst, ena, start;
  logic [31:0]  dataA, dataB;
  logic [127:0] key;
  logic [31:0]  resultA, resultB;
  logic         busy, rdy;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] ZERO_CT = 64'h41EA3A0A_94BAA940;

  tea_encryptor dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start),
    .dataA(dataA), .dataB(dataB), .key(key),
    .resultA(resultA), .resultB(resultB), .busy(busy), .rdy(rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference TEA encryption, straight from the algorithm definition.
  function automatic logic [63:0] refEnc(input logic [127:0] k, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] v0, v1, s, k0, k1, k2, k3;
    {k0, k1, k2, k3} = k;
    v0 = a; v1 = b; s = 32'd0;
    for (int i = 0; i < 32; i++) begin
      s  = s + 32'h9E3779B9;
      v0 = v0 + (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
      v1 = v1 + (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
    end
    return {v0, v1};
  endfunction

  // Reference TEA decryption, used for the round-trip property.
  function automatic logic [63:0] refDec(input logic [127:0] k, input logic [63:0] c);
    logic [31:0] v0, v1, s, k0, k1, k2, k3;
    {k0, k1, k2, k3} = k;
    {v0, v1} = c;
    s = 32'hC6EF3720;
    for (int i = 0; i < 32; i++) begin
      v1 = v1 - (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
      v0 = v0 - (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
      s  = s - 32'h9E3779B9;
    end
    return {v0, v1};
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [127:0] rndKey();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Issue one block from a negedge; inputs are scrambled after acceptance.
  // gateAt >= 0 drops ena for 7 cycles once that many edges have elapsed.
  task automatic runBlock(input logic [127:0] k, input logic [31:0] a, input logic [31:0] b,
                          input int gateAt, output logic [63:0] res, output int edges);
    key = k; dataA = a; dataB = b; start = 1'b1;
    stepCycle();
    edges = 1;
    start = 1'b0;
    key = rndKey(); dataA = $urandom; dataB = $urandom;
    while (!rdy && edges < 200) begin
      if (edges == 5) chk("busy_run", 64'(busy), 64'd1);
      if (edges == gateAt) begin
        ena = 1'b0;
        repeat (7) stepCycle();
        edges += 7;
        ena = 1'b1;
      end
      stepCycle();
      edges++;
    end
    res = {resultA, resultB};
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k, k2;
    logic [31:0]  a, b;
    logic [63:0]  res, exp;
    int           e, pulses, firstAt, prev, cyc, badIv, badCt, badBusy;

    rst = 1'b0; ena = 1'b1; start = 1'b0; dataA = '0; dataB = '0; key = '0;
    #2 rst = 1'b1;
    #1;
    chk("reset_result", {resultA, resultB}, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rdy", 64'(rdy), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    stepCycle();
    chk("idle_busy", 64'(busy), 64'd0);

    // All-zero known-answer vector.
    runBlock('0, 32'd0, 32'd0, -1, res, e);
    chk("zero_latency", 64'(e), 64'd33);
    chk("zero_ct", res, ZERO_CT);
    chk("zero_done_busy", 64'(busy), 64'd0);
    stepCycle();
    chk("zero_single_pulse", 64'(rdy), 64'd0);
    chk("zero_hold", {resultA, resultB}, ZERO_CT);

    // Random vectors, chained DONE->RUN, with round-trip decryption.
    for (int i = 0; i < 100; i++) begin
      k = rndKey(); a = $urandom; b = $urandom;
      runBlock(k, a, b, -1, res, e);
      chk("rnd_latency", 64'(e), 64'd33);
      chk("rnd_ct", res, refEnc(k, a, b));
      chk("rnd_roundtrip", refDec(k, res), {a, b});
    end
    stepCycle();

    // Clock-enable gap of 7 cycles mid-run, then freeze in DONE.
    k = rndKey(); a = $urandom; b = $urandom;
    exp = refEnc(k, a, b);
    runBlock(k, a, b, 12, res, e);
    chk("gate_latency", 64'(e), 64'd40);
    chk("gate_ct", res, exp);
    ena = 1'b0;
    repeat (3) stepCycle();
    chk("freeze_rdy", 64'(rdy), 64'd1);
    chk("freeze_ct", {resultA, resultB}, exp);
    ena = 1'b1;
    stepCycle();
    chk("unfreeze_rdy", 64'(rdy), 64'd0);

    // Second start at round 10 must be ignored.
    k = rndKey(); a = $urandom; b = $urandom;
    exp = refEnc(k, a, b);
    key = k; dataA = a; dataB = b; start = 1'b1;
    stepCycle();
    start = 1'b0;
    repeat (10) stepCycle();
    k2 = rndKey();
    key = k2; dataA = ~a; dataB = ~b; start = 1'b1;
    stepCycle();
    start = 1'b0;
    e = 12; pulses = 0; firstAt = 0; res = '0;
    for (int i = 0; i < 50; i++) begin
      if (rdy) begin
        pulses++;
        if (firstAt == 0) begin firstAt = e; res = {resultA, resultB}; end
      end
      stepCycle();
      e++;
    end
    chk("restart_pulses", 64'(pulses), 64'd1);
    chk("restart_latency", 64'(firstAt), 64'd33);
    chk("restart_ct", res, exp);

    // Reset at round 20 aborts the block.
    k = rndKey(); a = $urandom; b = $urandom;
    key = k; dataA = a; dataB = b; start = 1'b1;
    stepCycle();
    start = 1'b0;
    repeat (20) stepCycle();
    #2 rst = 1'b1;
    #1;
    chk("midrst_result", {resultA, resultB}, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_rdy", 64'(rdy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      stepCycle();
      if (rdy) pulses++;
    end
    chk("midrst_no_rdy", 64'(pulses), 64'd0);
    runBlock('0, 32'd0, 32'd0, -1, res, e);
    chk("postrst_latency", 64'(e), 64'd33);
    chk("postrst_ct", res, ZERO_CT);

    // start held high: back-to-back blocks every 33 cycles.
    k = rndKey(); a = $urandom; b = $urandom;
    exp = refEnc(k, a, b);
    key = k; dataA = a; dataB = b; start = 1'b1;
    pulses = 0; prev = 0; firstAt = 0; badIv = 0; badCt = 0; badBusy = 0;
    for (cyc = 1; cyc <= 105; cyc++) begin
      stepCycle();
      if (busy == rdy) badBusy++;
      if (rdy) begin
        pulses++;
        if (firstAt == 0) firstAt = cyc;
        if (prev != 0 && cyc - prev != 33) badIv++;
        if ({resultA, resultB} !== exp) badCt++;
        prev = cyc;
      end
    end
    start = 1'b0;
    chk("b2b_pulses", 64'(pulses), 64'd3);
    chk("b2b_first", 64'(firstAt), 64'd33);
    chk("b2b_interval", 64'(badIv), 64'd0);
    chk("b2b_ct", 64'(badCt), 64'd0);
    chk("b2b_busy", 64'(badBusy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
